fruit_classify_vote: RTL and testbench
======================================

FRUIT_CLASSIFY_VOTE -- requirements
Module: fruit_classify_vote

Interface
REQ-001 SHALL have parameter NUM_SCORES, default 11, meaning the number of shape-score channels (2..15).
REQ-002 SHALL have parameter SCORE_W, default 24, meaning the width of one score channel.
REQ-003 SHALL have parameter VOTE_DEPTH, default 4, meaning the class-history length (1..8).
REQ-004 SHALL have parameter VOTE_MIN, default 3, meaning the minimum history matches needed to commit a class (1..VOTE_DEPTH).
REQ-005 pixelclk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 i_rgb/i_hsync/i_vsync/i_de  in  24/1/1/1  video in.
REQ-008 area  in  16  object pixel area.
REQ-009 f1  in  8  form factor.
REQ-010 scores  in  NUM_SCORES*SCORE_W  channel k at bits [k*SCORE_W +: SCORE_W].
REQ-011 area_min, area_small  in  16, 16  runtime area thresholds.
REQ-012 f1_hi  in  8  runtime form-factor threshold.
REQ-013 o_rgb/o_hsync/o_vsync/o_de  out  24/1/1/1  video out.
REQ-014 sort  out  4  committed class.
REQ-015 sort_raw  out  4  latest per-frame class.
REQ-016 sort_valid  out  1  one-cycle pulse when sort_raw updates.
REQ-017 votes  out  4  history match count of sort_raw.
REQ-018 frame_drop  out  1  one-cycle pulse when a frame is skipped.

Function
REQ-019 Video outputs SHALL equal the inputs delayed by exactly one pixelclk, unaffected by the FSM.
REQ-020 The frame trigger SHALL be the cycle where registered i_vsync is 0 and i_vsync is 1 (rising edge).
REQ-021 FSM states SHALL be IDLE, CAPTURE, ARGMAX, DECIDE, VOTE; a trigger in IDLE moves to CAPTURE on the next edge.
REQ-022 CAPTURE (1 cycle) SHALL snapshot area, f1, scores, area_min, area_small and f1_hi; later input changes SHALL NOT affect the frame.
REQ-023 ARGMAX SHALL last exactly NUM_SCORES cycles, comparing one channel per cycle in index order 0..NUM_SCORES-1, unsigned.
REQ-024 Argmax SHALL replace the best only on strictly greater, so ties resolve to the lowest index.
REQ-025 DECIDE (1 cycle) SHALL set the class, first match winning:
- area < area_min -> 0
- area < area_small -> 6
- f1 > f1_hi -> 5
- otherwise -> best_index+1, saturated at 15
REQ-026 VOTE (1 cycle) SHALL:
- shift the class into the history, discarding the oldest entry
- write sort_raw
- compute votes as the number of history entries, including the new one, equal to the class
- pulse sort_valid
- return to IDLE
REQ-027 sort SHALL load sort_raw in VOTE only when votes >= VOTE_MIN, else hold its value.
REQ-028 sort_valid SHALL occur exactly NUM_SCORES+3 cycles after the trigger cycle.
REQ-029 A trigger while the FSM is not IDLE SHALL be discarded and pulse frame_drop that cycle; the running evaluation SHALL complete unchanged.
REQ-030 A trigger coinciding with the VOTE cycle SHALL count as a drop (REQ-029).
REQ-031 VOTE_DEPTH=1 with VOTE_MIN=1 SHALL make sort follow sort_raw every frame.

Reset
REQ-032 While reset is high, on each edge:
- FSM -> IDLE
- all history entries -> 0
- sort, sort_raw, votes -> 0
- sort_valid, frame_drop -> 0
- o_* -> 0
REQ-033 Reset mid-evaluation SHALL abort it with no sort_valid pulse.
REQ-034 The first frame after reset SHALL NOT count as a trigger unless i_vsync was 0 on the last reset cycle.

Verification
REQ-035 Defaults; area=0x0500, area_min=0x20, area_small=0x88, f1=0x10, f1_hi=0x21, scores channel 7 largest; one vsync edge -> sort_valid 14 cycles after the trigger, sort_raw=8, votes=1, sort=0.
REQ-036 Same stimulus over 3 consecutive frames -> third frame votes=3 and sort=8; frames 1-2 keep sort=0.
REQ-037 Channels 2 and 9 equal maximum -> sort_raw=3 (lowest index wins).
REQ-038 Classification rules:
- area=0x10 -> sort_raw=0
- area=0x50 -> sort_raw=6
- f1=0x30 with area=0x500 -> sort_raw=5
REQ-039 Second vsync edge 5 cycles after the first -> frame_drop pulse, exactly one sort_valid, result from the first snapshot.
REQ-040 Reset asserted during ARGMAX -> no sort_valid; sort=0, votes=0, history cleared; next frame gives votes=1.

Source files
------------

// File: rtl/fruit_classify_vote.sv
// fruit_classify_vote: per-frame fruit classifier with a majority-style vote over recent frames.
//
// Video passes through with one pixelclk of delay. On each rising edge of i_vsync the block
// snapshots the object features and runs an FSM: IDLE -> CAPTURE -> ARGMAX (NUM_SCORES cycles,
// one channel per cycle) -> DECIDE -> VOTE -> IDLE. The class is pushed into a short history;
// the committed class `sort` only moves when enough history entries agree.
//
// Ports:
//   pixelclk, reset              clock and synchronous active-high reset
//   i_rgb/i_hsync/i_vsync/i_de   video in
//   o_rgb/o_hsync/o_vsync/o_de   video out, one cycle later
//   area, f1, scores             object features (score channel k at [k*SCORE_W +: SCORE_W])
//   area_min, area_small, f1_hi  runtime thresholds
//   sort                         committed class
//   sort_raw, votes, sort_valid  latest class, its history match count, update pulse
//   frame_drop                   pulse for a trigger that arrived while busy
module fruit_classify_vote #(
    parameter int unsigned NUM_SCORES = 11,
    parameter int unsigned SCORE_W    = 24,
    parameter int unsigned VOTE_DEPTH = 4,
    parameter int unsigned VOTE_MIN   = 3
) (
    input  logic                          pixelclk,
    input  logic                          reset,
    input  logic [23:0]                   i_rgb,
    input  logic                          i_hsync,
    input  logic                          i_vsync,
    input  logic                          i_de,
    input  logic [15:0]                   area,
    input  logic [7:0]                    f1,
    input  logic [NUM_SCORES*SCORE_W-1:0] scores,
    input  logic [15:0]                   area_min,
    input  logic [15:0]                   area_small,
    input  logic [7:0]                    f1_hi,
    output logic [23:0]                   o_rgb,
    output logic                          o_hsync,
    output logic                          o_vsync,
    output logic                          o_de,
    output logic [3:0]                    sort,
    output logic [3:0]                    sort_raw,
    output logic                          sort_valid,
    output logic [3:0]                    votes,
    output logic                          frame_drop
);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCapture = 3'd1;
    localparam logic [2:0] StArgmax  = 3'd2;
    localparam logic [2:0] StDecide  = 3'd3;
    localparam logic [2:0] StVote    = 3'd4;

    localparam logic [3:0] LastIdx = 4'(NUM_SCORES - 1);

    logic [2:0]                    state_q, state_d;
    logic                          vsync_prev_q;
    logic                          trigger;
    logic [3:0]                    idx_q;
    logic [3:0]                    best_idx_q;
    logic [SCORE_W-1:0]            best_val_q;
    logic [SCORE_W-1:0]            score_sel;
    logic                          take_best;
    logic [15:0]                   area_q, area_min_q, area_small_q;
    logic [7:0]                    f1_q, f1_hi_q;
    logic [NUM_SCORES*SCORE_W-1:0] scores_q;
    logic [3:0]                    hist_q [VOTE_DEPTH];
    logic [3:0]                    class_d;
    logic [3:0]                    votes_d;

    // Kept apart from o_vsync and loaded even during reset, so a vsync already high when
    // reset drops is not mistaken for a new frame.
    always_ff @(posedge pixelclk) begin
        vsync_prev_q <= i_vsync;
    end

    assign trigger = ~vsync_prev_q & i_vsync;

    always_ff @(posedge pixelclk) begin
        if (reset) begin
            o_rgb   <= '0;
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
        end else begin
            o_rgb   <= i_rgb;
            o_hsync <= i_hsync;
            o_vsync <= i_vsync;
            o_de    <= i_de;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (trigger) state_d = StCapture;
            StCapture: state_d = StArgmax;
            StArgmax:  if (idx_q == LastIdx) state_d = StDecide;
            StDecide:  state_d = StVote;
            StVote:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        score_sel = '0;
        for (int k = 0; k < int'(NUM_SCORES); k++) begin
            if (idx_q == 4'(k)) score_sel = scores_q[k*SCORE_W +: SCORE_W];
        end
    end

    // Channel 0 seeds the running best; afterwards only a strictly larger score replaces it,
    // so ties keep the lowest index.
    assign take_best = (idx_q == 4'd0) || (score_sel > best_val_q);

    always_comb begin
        if (area_q < area_min_q) begin
            class_d = 4'd0;
        end else if (area_q < area_small_q) begin
            class_d = 4'd6;
        end else if (f1_q > f1_hi_q) begin
            class_d = 4'd5;
        end else if (best_idx_q == 4'd15) begin
            class_d = 4'd15;
        end else begin
            class_d = best_idx_q + 4'd1;
        end
    end

    // The new entry always matches itself; the oldest entry is about to be discarded.
    always_comb begin
        votes_d = 4'd1;
        for (int i = 0; i < int'(VOTE_DEPTH) - 1; i++) begin
            if (hist_q[i] == class_d) votes_d = votes_d + 4'd1;
        end
    end

    always_ff @(posedge pixelclk) begin
        if (state_q == StCapture) begin
            area_q       <= area;
            f1_q         <= f1;
            scores_q     <= scores;
            area_min_q   <= area_min;
            area_small_q <= area_small;
            f1_hi_q      <= f1_hi;
        end
    end

    // The VOTE results are registered on the edge that enters VOTE, so sort_raw, votes, sort
    // and the sort_valid pulse are all visible during the VOTE cycle itself.
    always_ff @(posedge pixelclk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
            sort       <= '0;
            sort_raw   <= '0;
            votes      <= '0;
            sort_valid <= 1'b0;
            frame_drop <= 1'b0;
            for (int i = 0; i < int'(VOTE_DEPTH); i++) hist_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sort_valid <= 1'b0;
            frame_drop <= trigger && (state_q != StIdle);
            case (state_q)
                StCapture: idx_q <= '0;
                StArgmax: begin
                    if (take_best) begin
                        best_val_q <= score_sel;
                        best_idx_q <= idx_q;
                    end
                    idx_q <= idx_q + 4'd1;
                end
                StDecide: begin
                    hist_q[0] <= class_d;
                    for (int i = 1; i < int'(VOTE_DEPTH); i++) hist_q[i] <= hist_q[i-1];
                    sort_raw   <= class_d;
                    votes      <= votes_d;
                    sort_valid <= 1'b1;
                    if (votes_d >= 4'(VOTE_MIN)) sort <= class_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fruit_classify_vote.sv
module tb_fruit_classify_vote;

    localparam int NS = 11;
    localparam int SW = 24;

    logic           pixelclk;
    logic           reset;
    logic [23:0]    i_rgb;
    logic           i_hsync, i_vsync, i_de;
    logic [15:0]    area, area_min, area_small;
    logic [7:0]     f1, f1_hi;
    logic [NS*SW-1:0] scores;
    logic [23:0]    o_rgb;
    logic           o_hsync, o_vsync, o_de;
    logic [3:0]     sort, sort_raw, votes;
    logic           sort_valid, frame_drop;

    int checks;
    int failures;
    int n_valid, n_drop, lat;
    logic [3:0] got_raw, got_votes, got_sort;
    logic [23:0] last_rgb;
    logic        last_hs;
    logic [23:0] vid [4] = '{24'h111111, 24'h2468AC, 24'hF0F0F0, 24'h00FF00};

    fruit_classify_vote dut (
        .pixelclk   (pixelclk),
        .reset      (reset),
        .i_rgb      (i_rgb),
        .i_hsync    (i_hsync),
        .i_vsync    (i_vsync),
        .i_de       (i_de),
        .area       (area),
        .f1         (f1),
        .scores     (scores),
        .area_min   (area_min),
        .area_small (area_small),
        .f1_hi      (f1_hi),
        .o_rgb      (o_rgb),
        .o_hsync    (o_hsync),
        .o_vsync    (o_vsync),
        .o_de       (o_de),
        .sort       (sort),
        .sort_raw   (sort_raw),
        .sort_valid (sort_valid),
        .votes      (votes),
        .frame_drop (frame_drop)
    );

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Ascending background so an argmax that ignores the big channel picks channel 10.
    task automatic set_scores(input int big_a, input int big_b);
        for (int k = 0; k < NS; k++) scores[k*SW +: SW] = 24'(32'h100 + k);
        scores[big_a*SW +: SW] = 24'hFFFFF0;
        if (big_b >= 0) scores[big_b*SW +: SW] = 24'hFFFFF0;
    endtask

    task automatic set_default();
        area       = 16'h0500;
        area_min   = 16'h0020;
        area_small = 16'h0088;
        f1         = 8'h10;
        f1_hi      = 8'h21;
        set_scores(7, -1);
    endtask

    // Raises vsync at k=0, optionally raises it again at rise2_at and shrinks area at alter_at.
    task automatic run_frame(input int rise2_at, input int alter_at);
        n_valid = 0;
        n_drop  = 0;
        lat     = -1;
        got_raw = '0; got_votes = '0; got_sort = '0;
        @(negedge pixelclk);
        i_vsync = 1'b0;
        @(negedge pixelclk);
        i_vsync = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge pixelclk);
            if (sort_valid) begin
                n_valid++;
                if (lat < 0) begin
                    lat       = k;
                    got_raw   = sort_raw;
                    got_votes = votes;
                    got_sort  = sort;
                end
            end
            if (frame_drop) n_drop++;
            if (k == 2) i_vsync = 1'b0;
            if (k == rise2_at) i_vsync = 1'b1;
            if (k == rise2_at + 2) i_vsync = 1'b0;
            if (k == alter_at) area = 16'h0010;
        end
    endtask

    task automatic frame(input string tag, input int rise2_at, input int alter_at,
                         input logic [3:0] e_raw, input logic [3:0] e_votes,
                         input logic [3:0] e_sort, input int e_drops);
        run_frame(rise2_at, alter_at);
        check({tag, "_valid_count"}, 32'(n_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'd14);
        check({tag, "_sort_raw"}, 32'(got_raw), 32'(e_raw));
        check({tag, "_votes"}, 32'(got_votes), 32'(e_votes));
        check({tag, "_sort"}, 32'(got_sort), 32'(e_sort));
        check({tag, "_drops"}, 32'(n_drop), 32'(e_drops));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        i_rgb    = 24'hABCDEF;
        i_hsync  = 1'b1;
        i_vsync  = 1'b0;
        i_de     = 1'b1;
        set_default();
        repeat (3) @(negedge pixelclk);
        check("rst_o_rgb", 32'(o_rgb), 32'd0);
        check("rst_o_de", 32'(o_de), 32'd0);
        check("rst_sort", 32'(sort), 32'd0);
        check("rst_sort_raw", 32'(sort_raw), 32'd0);
        check("rst_votes", 32'(votes), 32'd0);
        check("rst_sort_valid", 32'(sort_valid), 32'd0);
        check("rst_frame_drop", 32'(frame_drop), 32'd0);
        reset    = 1'b0;
        last_rgb = i_rgb;
        last_hs  = i_hsync;

        // Video pass-through: each sample appears exactly one cycle later.
        for (int i = 0; i < 4; i++) begin
            @(negedge pixelclk);
            check("vid_rgb", 32'(o_rgb), 32'(last_rgb));
            check("vid_hsync", 32'(o_hsync), 32'(last_hs));
            i_rgb    = vid[i];
            i_hsync  = ~i_hsync;
            last_rgb = i_rgb;
            last_hs  = i_hsync;
        end

        // History trace: [8,0,0,0] [8,8,0,0] [8,8,8,0]
        set_default();
        frame("f1", 0, 0, 4'd8, 4'd1, 4'd0, 0);
        frame("f2", 0, 0, 4'd8, 4'd2, 4'd0, 0);
        frame("f3", 0, 0, 4'd8, 4'd3, 4'd8, 0);
        // Tie between channels 2 and 9 -> class 3; history [3,8,8,8]
        set_scores(2, 9);
        frame("tie", 0, 0, 4'd3, 4'd1, 4'd8, 0);
        set_default();
        area = 16'h0010;
        frame("area_min", 0, 0, 4'd0, 4'd1, 4'd8, 0);
        area = 16'h0050;
        frame("area_small", 0, 0, 4'd6, 4'd1, 4'd8, 0);
        set_default();
        f1 = 8'h30;
        frame("f1_hi", 0, 0, 4'd5, 4'd1, 4'd8, 0);
        // Second edge during ARGMAX; area shrinks after the snapshot. History [8,5,6,0]
        set_default();
        frame("drop_argmax", 5, 3, 4'd8, 4'd1, 4'd8, 1);
        // Second edge in the VOTE cycle. History [8,8,5,6]
        set_default();
        frame("drop_vote", 14, 0, 4'd8, 4'd2, 4'd8, 1);

        // Reset during ARGMAX aborts the frame and clears history.
        set_default();
        n_valid = 0;
        @(negedge pixelclk);
        i_vsync = 1'b0;
        @(negedge pixelclk);
        i_vsync = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge pixelclk);
            if (sort_valid) n_valid++;
            if (k == 2) i_vsync = 1'b0;
            if (k == 4) reset = 1'b1;
            if (k == 6) reset = 1'b0;
        end
        check("rstmid_no_valid", 32'(n_valid), 32'd0);
        check("rstmid_sort", 32'(sort), 32'd0);
        check("rstmid_votes", 32'(votes), 32'd0);
        check("rstmid_sort_raw", 32'(sort_raw), 32'd0);
        frame("post_rst", 0, 0, 4'd8, 4'd1, 4'd0, 0);

        // vsync already high on the last reset cycle: no frame after release.
        @(negedge pixelclk);
        i_vsync = 1'b1;
        reset   = 1'b1;
        @(negedge pixelclk);
        @(negedge pixelclk);
        reset   = 1'b0;
        n_valid = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge pixelclk);
            if (sort_valid) n_valid++;
        end
        check("rst_vsync_high_no_frame", 32'(n_valid), 32'd0);
        i_vsync = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
